// File: rtl/tlul_ddr4_gate.sv
// TL-UL gate in front of the DDR4 subsystem: holds traffic until
// calibration, caps outstanding requests and answers out-of-window locally.
package tlul_ddr4_pkg;

    localparam logic [2:0] OpPutFull       = 3'd0;
    localparam logic [2:0] OpPutPartial    = 3'd1;
    localparam logic [2:0] OpGet           = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_ddr4_gate
    import tlul_ddr4_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [31:0] BaseAddr       = 32'h8000_0000,
    parameter logic [31:0] WindowSize     = 32'h4000_0000,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       init_calib_done_i,
    input  tl_h2d_t    tl_h_i,
    output tl_d2h_t    tl_h_o,
    output tl_h2d_t    tl_d_o,
    input  tl_d2h_t    tl_d_i,
    output logic [3:0] outstanding_o,
    output logic       ready_o,
    output logic       timeout_o
);

    localparam int TW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        CalibWait,
        Run,
        ErrRsp
    } state_e;

    state_e        state_q, state_d;
    logic          calib_s1_q, calib_s2_q;
    logic [3:0]    count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;
    logic [2:0]    err_op_q, err_op_d;
    logic [7:0]    err_src_q, err_src_d;
    logic [1:0]    err_size_q, err_size_d;

    logic in_win, is_run, accept_ok, err_take;
    logic a_hs, d_hs, d_cnt;

    assign in_win    = (tl_h_i.a_address & ~(WindowSize - 32'd1)) == BaseAddr;
    assign is_run    = (state_q == Run);
    assign accept_ok = is_run && calib_s2_q && (count_q < 4'(MaxOutstanding));
    // Out-of-window requests are only answered once the device side is idle,
    // so the local error response cannot overtake an in-flight device beat.
    assign err_take  = is_run && calib_s2_q && tl_h_i.a_valid && !in_win
                       && (count_q == 4'd0);

    always_comb begin
        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = 1'b0;
        tl_d_o.d_ready = 1'b0;
        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = 1'b0;
        tl_h_o.d_valid = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                Run: begin
                    tl_d_o.a_valid = tl_h_i.a_valid && in_win && accept_ok;
                    tl_d_o.d_ready = tl_h_i.d_ready;
                    tl_h_o.a_ready = (tl_d_i.a_ready && in_win && accept_ok)
                                     || err_take;
                    tl_h_o.d_valid = tl_d_i.d_valid;
                end
                ErrRsp: begin
                    tl_h_o.d_valid  = 1'b1;
                    tl_h_o.d_opcode = (err_op_q == OpGet) ? OpAccessAckData
                                                          : OpAccessAck;
                    tl_h_o.d_param  = 3'd0;
                    tl_h_o.d_size   = err_size_q;
                    tl_h_o.d_source = err_src_q;
                    tl_h_o.d_sink   = 1'b0;
                    tl_h_o.d_data   = 32'd0;
                    tl_h_o.d_error  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign a_hs  = tl_d_o.a_valid && tl_d_i.a_ready;
    assign d_hs  = tl_d_i.d_valid && tl_d_o.d_ready;
    assign d_cnt = d_hs && (count_q != 4'd0);

    always_comb begin
        count_d = count_q;
        if (a_hs && !d_cnt) begin
            count_d = count_q + 4'd1;
        end else if (!a_hs && d_cnt) begin
            count_d = count_q - 4'd1;
        end

        timer_d = timer_q;
        if (d_hs || count_q == 4'd0) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + TW'(1);
        end
        timeout_d = timeout_q || (timer_q == TW'(TimeoutCycles - 1));

        state_d    = state_q;
        err_op_d   = err_op_q;
        err_src_d  = err_src_q;
        err_size_d = err_size_q;
        unique case (state_q)
            CalibWait: begin
                if (calib_s2_q) state_d = Run;
            end
            Run: begin
                if (err_take) begin
                    state_d    = ErrRsp;
                    err_op_d   = tl_h_i.a_opcode;
                    err_src_d  = tl_h_i.a_source;
                    err_size_d = tl_h_i.a_size;
                end else if (!calib_s2_q && count_q == 4'd0) begin
                    state_d = CalibWait;
                end
            end
            ErrRsp: begin
                if (tl_h_i.d_ready) state_d = Run;
            end
            default: state_d = CalibWait;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CalibWait;
            calib_s1_q <= 1'b0;
            calib_s2_q <= 1'b0;
            count_q    <= 4'd0;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
            err_op_q   <= 3'd0;
            err_src_q  <= 8'd0;
            err_size_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            calib_s1_q <= init_calib_done_i;
            calib_s2_q <= calib_s1_q;
            count_q    <= count_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
            err_op_q   <= err_op_d;
            err_src_q  <= err_src_d;
            err_size_q <= err_size_d;
        end
    end

    assign outstanding_o = count_q;
    assign ready_o       = (state_q == Run) || (state_q == ErrRsp);
    assign timeout_o     = timeout_q;

    d_beat_while_idle: assert property (
        @(posedge clk_i) disable iff (rst_i) !(d_hs && count_q == 4'd0)
    );

endmodule

// File: tb/tb_tlul_ddr4_gate.sv
// Directed bench for tlul_ddr4_gate with a cycle-level reference model
// and hand-computed checkpoints.
module tb_tlul_ddr4_gate;
    import tlul_ddr4_pkg::*;

    localparam int MAXO = 4;
    localparam int TC   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       calib;
    tl_h2d_t    h;
    tl_d2h_t    dv;
    tl_d2h_t    ho;
    tl_h2d_t    dout;
    logic [3:0] outst;
    logic       rdy;
    logic       tmo;

    always #5 clk = ~clk;

    tlul_ddr4_gate #(
        .MaxOutstanding(MAXO),
        .BaseAddr(32'h8000_0000),
        .WindowSize(32'h4000_0000),
        .TimeoutCycles(TC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .init_calib_done_i(calib),
        .tl_h_i(h),
        .tl_h_o(ho),
        .tl_d_o(dout),
        .tl_d_i(dv),
        .outstanding_o(outst),
        .ready_o(rdy),
        .timeout_o(tmo)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: mode 0=waiting for calibration, 1=running, 2=error reply
    int         m_mode = 0, m_cnt = 0, m_timer = 0;
    bit         m_to = 0, c1 = 0, c2 = 0, m_eget = 0;
    logic [7:0] m_esrc = 8'd0;
    logic [1:0] m_esz = 2'd0;
    int         n_mode, n_cnt, n_timer;
    bit         n_to, n_c1, n_c2, n_eget;
    logic [7:0] n_esrc;
    logic [1:0] n_esz;

    always @(negedge clk) begin : model_cmp
        bit win, run, err, open, e_dav, e_har, e_ddr, e_hdv;
        bit ahs, dhs, take;
        win   = h.a_address >= 32'h8000_0000 && h.a_address < 32'hC000_0000;
        run   = (m_mode == 1);
        err   = (m_mode == 2);
        open  = run && c2 && (m_cnt < MAXO);
        take  = !rst && run && c2 && h.a_valid && !win && m_cnt == 0;
        e_dav = !rst && open && h.a_valid && win;
        e_har = (!rst && open && win && dv.a_ready) || take;
        e_ddr = !rst && run && h.d_ready;
        e_hdv = !rst && (run ? dv.d_valid : err);

        chk("m_dev_a_valid", 32'(dout.a_valid), 32'(e_dav));
        chk("m_host_a_ready", 32'(ho.a_ready), 32'(e_har));
        chk("m_dev_d_ready", 32'(dout.d_ready), 32'(e_ddr));
        chk("m_host_d_valid", 32'(ho.d_valid), 32'(e_hdv));
        chk("m_outstanding", 32'(outst), 32'(m_cnt));
        chk("m_ready", 32'(rdy), 32'(run || err));
        chk("m_timeout", 32'(tmo), 32'(m_to));
        if (e_dav) begin
            chk("m_fwd_addr", dout.a_address, h.a_address);
            chk("m_fwd_src", 32'(dout.a_source), 32'(h.a_source));
            chk("m_fwd_op", 32'(dout.a_opcode), 32'(h.a_opcode));
        end
        if (!rst && err) begin
            chk("m_err_op", 32'(ho.d_opcode), m_eget ? 32'd1 : 32'd0);
            chk("m_err_flag", 32'(ho.d_error), 32'd1);
            chk("m_err_src", 32'(ho.d_source), 32'(m_esrc));
            chk("m_err_size", 32'(ho.d_size), 32'(m_esz));
            chk("m_err_data", ho.d_data, 32'd0);
        end else if (e_hdv) begin
            chk("m_rsp_data", ho.d_data, dv.d_data);
            chk("m_rsp_src", 32'(ho.d_source), 32'(dv.d_source));
        end

        ahs = e_dav && dv.a_ready;
        dhs = dv.d_valid && e_ddr;
        n_mode = m_mode; n_eget = m_eget; n_esrc = m_esrc; n_esz = m_esz;
        if (rst) begin
            n_mode = 0; n_cnt = 0; n_timer = 0; n_to = 0;
            n_c1 = 0; n_c2 = 0; n_eget = 0; n_esrc = 0; n_esz = 0;
        end else begin
            n_c1  = calib;
            n_c2  = c1;
            n_cnt = m_cnt + (ahs ? 1 : 0) - ((dhs && m_cnt > 0) ? 1 : 0);
            if (dhs || m_cnt == 0) n_timer = 0;
            else n_timer = (m_timer < 1000) ? m_timer + 1 : m_timer;
            n_to = m_to || (m_timer == TC - 1);
            if (m_mode == 0) begin
                if (c2) n_mode = 1;
            end else if (m_mode == 1) begin
                if (take) begin
                    n_mode = 2;
                    n_eget = (h.a_opcode == OpGet);
                    n_esrc = h.a_source;
                    n_esz  = h.a_size;
                end else if (!c2 && m_cnt == 0) begin
                    n_mode = 0;
                end
            end else if (h.d_ready) begin
                n_mode = 1;
            end
        end
    end

    always @(posedge clk) begin
        m_mode  <= n_mode;
        m_cnt   <= n_cnt;
        m_timer <= n_timer;
        m_to    <= n_to;
        c1      <= n_c1;
        c2      <= n_c2;
        m_eget  <= n_eget;
        m_esrc  <= n_esrc;
        m_esz   <= n_esz;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_req(input logic [2:0] op, input logic [31:0] addr,
                            input logic [7:0] src);
        h.a_valid   = 1'b1;
        h.a_opcode  = op;
        h.a_address = addr;
        h.a_source  = src;
        h.a_size    = 2'd2;
        h.a_mask    = 4'hF;
        h.a_data    = {24'hA5A500, src};
    endtask

    task automatic dev_d(input logic [7:0] src, input logic [31:0] data);
        dv.d_valid  = 1'b1;
        dv.d_opcode = OpAccessAckData;
        dv.d_source = src;
        dv.d_size   = 2'd2;
        dv.d_data   = data;
    endtask

    task automatic reset_and_run();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi, n, acc;
        rst   = 1'b1;
        calib = 1'b0;
        h     = '0;
        dv    = '0;
        dv.a_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_a_ready", 32'(ho.a_ready), 32'd0);
        chk("rst_d_valid", 32'(ho.d_valid), 32'd0);
        chk("rst_dev_a_valid", 32'(dout.a_valid), 32'd0);
        chk("rst_dev_d_ready", 32'(dout.d_ready), 32'd0);
        chk("rst_outst", 32'(outst), 32'd0);
        tick();
        rst = 1'b0;

        // Calibration gate
        host_req(OpGet, 32'h8000_0100, 8'h07);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ho.a_ready) hi++;
            tick();
        end
        chk("t1_blocked", hi, 0);
        calib = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ho.a_ready && n < 10) begin
            tick();
            n++;
            @(negedge clk);
        end
        chk("t1_calib_latency", n, 3);
        chk("t1_fwd_valid", 32'(dout.a_valid), 32'd1);
        chk("t1_fwd_addr", dout.a_address, 32'h8000_0100);
        tick();
        h.a_valid = 1'b0;
        @(negedge clk);
        chk("t1_outst", 32'(outst), 32'd1);
        tick();
        dev_d(8'h07, 32'hDEAD_BEEF);
        h.d_ready = 1'b1;
        @(negedge clk);
        chk("t1_rsp_data", ho.d_data, 32'hDEAD_BEEF);
        tick();
        dv.d_valid = 1'b0;
        @(negedge clk);
        chk("t1_drained", 32'(outst), 32'd0);

        // Outstanding cap
        tick();
        acc = 0;
        host_req(OpGet, 32'h8000_0200, 8'h10);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ho.a_ready) acc++;
            tick();
            h.a_source = 8'h10 + 8'(acc);
        end
        chk("t2_accepted", acc, 4);
        @(negedge clk);
        chk("t2_outst_full", 32'(outst), 32'd4);
        chk("t2_stall", 32'(ho.a_ready), 32'd0);
        tick();
        dev_d(8'h10, 32'h0000_0001);
        @(negedge clk);
        tick();
        dv.d_valid = 1'b0;
        @(negedge clk);
        chk("t2_after_d", 32'(outst), 32'd3);
        chk("t2_reopen", 32'(ho.a_ready), 32'd1);
        tick();
        h.a_valid = 1'b0;
        @(negedge clk);
        chk("t2_refill", 32'(outst), 32'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            dev_d(8'h11 + 8'(i), 32'h100 + 32'(i));
        end
        tick();
        dv.d_valid = 1'b0;
        @(negedge clk);
        chk("t2_drained", 32'(outst), 32'd0);

        // Local error responses
        tick();
        h.d_ready = 1'b0;
        host_req(OpGet, 32'h0000_1000, 8'h2A);
        @(negedge clk);
        chk("t3_err_accept", 32'(ho.a_ready), 32'd1);
        chk("t3_no_fwd", 32'(dout.a_valid), 32'd0);
        tick();
        h.a_valid = 1'b0;
        @(negedge clk);
        chk("t3_d_valid", 32'(ho.d_valid), 32'd1);
        chk("t3_opcode", 32'(ho.d_opcode), 32'd1);
        chk("t3_error", 32'(ho.d_error), 32'd1);
        chk("t3_source", 32'(ho.d_source), 32'h2A);
        chk("t3_a_ready", 32'(ho.a_ready), 32'd0);
        tick();
        h.d_ready = 1'b1;
        @(negedge clk);
        chk("t3_held", 32'(ho.d_valid), 32'd1);
        tick();
        host_req(OpPutFull, 32'hC000_0000, 8'h33);
        @(negedge clk);
        chk("t3_put_accept", 32'(ho.a_ready), 32'd1);
        tick();
        h.a_valid = 1'b0;
        @(negedge clk);
        chk("t3_put_opcode", 32'(ho.d_opcode), 32'd0);
        chk("t3_put_error", 32'(ho.d_error), 32'd1);
        chk("t3_put_source", 32'(ho.d_source), 32'h33);
        tick();

        // Error response ordered behind device responses
        host_req(OpGet, 32'h8000_0010, 8'h01);
        tick();
        host_req(OpGet, 32'h8000_0014, 8'h02);
        tick();
        host_req(OpPutPartial, 32'h0000_0040, 8'h03);
        @(negedge clk);
        chk("t4_outst", 32'(outst), 32'd2);
        chk("t4_stall0", 32'(ho.a_ready), 32'd0);
        tick();
        dev_d(8'h01, 32'h0000_1111);
        @(negedge clk);
        chk("t4_stall1", 32'(ho.a_ready), 32'd0);
        chk("t4_rsp1_src", 32'(ho.d_source), 32'h01);
        tick();
        dev_d(8'h02, 32'h0000_2222);
        @(negedge clk);
        chk("t4_stall2", 32'(ho.a_ready), 32'd0);
        tick();
        dv.d_valid = 1'b0;
        @(negedge clk);
        chk("t4_drained", 32'(outst), 32'd0);
        chk("t4_err_accept", 32'(ho.a_ready), 32'd1);
        tick();
        h.a_valid = 1'b0;
        @(negedge clk);
        chk("t4_err_valid", 32'(ho.d_valid), 32'd1);
        chk("t4_err_src", 32'(ho.d_source), 32'h03);
        chk("t4_err_op", 32'(ho.d_opcode), 32'd0);
        tick();

        // Sticky timeout
        reset_and_run();
        host_req(OpGet, 32'h8000_0020, 8'h05);
        @(negedge clk);
        chk("t5_accept", 32'(ho.a_ready), 32'd1);
        tick();
        h.a_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!tmo && n < 40) begin
            tick();
            n++;
            @(negedge clk);
        end
        chk("t5_timeout_cycle", n, 16);
        tick();
        dev_d(8'h05, 32'h0000_5555);
        tick();
        dv.d_valid = 1'b0;
        @(negedge clk);
        chk("t5_sticky", 32'(tmo), 32'd1);
        chk("t5_outst", 32'(outst), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_cleared", 32'(tmo), 32'd0);
        tick();

        // Reset with requests in flight
        reset_and_run();
        host_req(OpGet, 32'h8000_0040, 8'h40);
        tick();
        host_req(OpGet, 32'h8000_0044, 8'h41);
        tick();
        host_req(OpGet, 32'h8000_0048, 8'h42);
        tick();
        h.a_valid = 1'b0;
        @(negedge clk);
        chk("t6_outst", 32'(outst), 32'd3);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_a_ready", 32'(ho.a_ready), 32'd0);
        chk("t6_rst_dev_valid", 32'(dout.a_valid), 32'd0);
        tick();
        rst = 1'b0;
        dev_d(8'h40, 32'h0000_4444);
        @(negedge clk);
        chk("t6_outst_zero", 32'(outst), 32'd0);
        chk("t6_not_ready", 32'(rdy), 32'd0);
        chk("t6_drop_d_ready", 32'(dout.d_ready), 32'd0);
        chk("t6_drop_d_valid", 32'(ho.d_valid), 32'd0);
        tick();
        dv.d_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
